// File: rtl/ariane_regfile_watch.sv
// ariane_regfile_watch: 32-entry register file with asynchronous read ports,
// commit write ports and a sequenced "watch" trigger. Each watch stage
// compares one register (under a mask) against a programmed value; stages
// must match in order, each within WINDOW cycles of the previous one, and
// matching the last stage raises a one-cycle hit pulse plus a sticky flag.
//
// Optional feature macro: REGFILE_WATCH_EN. When undefined, the watch logic
// is not built: stage_o/hit_o/hit_sticky_o are tied to 0 and cfg_ready_o to
// 1 (configuration writes are accepted and discarded).
module ariane_regfile_watch #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG_ZERO  = 1'b1,
  parameter int unsigned NR_WATCH       = 4,
  parameter int unsigned WINDOW         = 1024,
  localparam int unsigned IDX_W         = (NR_WATCH > 1) ? $clog2(NR_WATCH) : 1,
  localparam int unsigned STAGE_W       = $clog2(NR_WATCH + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  // read ports, flattened: port p occupies slice [p*W +: W]
  input  logic [NR_READ_PORTS*5-1:0]              raddr_i,
  output logic [NR_READ_PORTS*DATA_WIDTH-1:0]     rdata_o,
  // commit write ports
  input  logic [NR_WRITE_PORTS*5-1:0]             waddr_i,
  input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]    wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]               we_i,
  // watch programming
  input  logic                                    cfg_valid_i,
  output logic                                    cfg_ready_o,
  input  logic [IDX_W-1:0]                        cfg_idx_i,
  input  logic [4:0]                              cfg_addr_i,
  input  logic [DATA_WIDTH-1:0]                   cfg_value_i,
  input  logic [DATA_WIDTH-1:0]                   cfg_mask_i,
  // watch control and status
  input  logic                                    arm_i,
  input  logic                                    clear_i,
  output logic [STAGE_W-1:0]                      stage_o,
  output logic                                    hit_o,
  output logic                                    hit_sticky_o
);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [32];

  // Combinational read of every port. x0 is never written when
  // ZERO_REG_ZERO is set, so it always reads back its reset value of zero.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    rdata_o = '0;
    for (int p = 0; p < NR_READ_PORTS; p++) begin
      rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_i[p*5 +: 5]];
    end
  end

  // Write all enabled ports on the rising edge; the highest-index port wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: this storage is clocked flops and must read back as zero after
      // reset, so it is cleared here; a RAM macro could not be reset this way.
      mem_q <= '{default: '0};
    end else begin
      for (int w = 0; w < NR_WRITE_PORTS; w++) begin
        if (we_i[w] && !(ZERO_REG_ZERO && (waddr_i[w*5 +: 5] == 5'd0))) begin
          // NOTE: non-blocking assignments to the same entry resolve to the
          // last one executed, so iterating ports upward gives the
          // highest-index port priority on an address conflict.
          mem_q[waddr_i[w*5 +: 5]] <= wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

`ifdef REGFILE_WATCH_EN
  // ---------------------------------------------------------------------------
  // Watch sequencer
  // ---------------------------------------------------------------------------
  localparam int unsigned CNT_W = $clog2(WINDOW) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HIT   = 2'd2
  } state_e;

  state_e                state_q;
  logic [STAGE_W-1:0]    stage_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  hit_q;
  logic                  sticky_q;
  logic                  arm_prev_q;

  logic [4:0]            w_addr_q  [NR_WATCH];
  logic [DATA_WIDTH-1:0] w_value_q [NR_WATCH];
  logic [DATA_WIDTH-1:0] w_mask_q  [NR_WATCH];

  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_match;
  logic                  last_stage;
  logic                  window_expire;
  logic                  arm_rise;
  logic                  final_match;

  // Compare the register watched by the current stage against its target.
  always_comb begin
    cur_idx       = stage_q[IDX_W-1:0];
    cur_match     = ((mem_q[w_addr_q[cur_idx]] ^ w_value_q[cur_idx])
                     & w_mask_q[cur_idx]) == '0;
    last_stage    = (stage_q == STAGE_W'(NR_WATCH - 1));
    // The counter "reaches" WINDOW-1 on the edge that would load that value.
    window_expire = (cnt_q == CNT_W'(WINDOW - 2));
    arm_rise      = arm_i && !arm_prev_q;
    final_match   = (state_q == S_ARMED) && arm_i && cur_match && last_stage;
  end

  // Capture stage programming; only accepted while the sequencer is idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_addr_q  <= '{default: '0};
      w_value_q <= '{default: '0};
      w_mask_q  <= '{default: '0};
    end else if (cfg_valid_i && (state_q == S_IDLE)
                 && (32'(cfg_idx_i) < NR_WATCH)) begin
      w_addr_q[cfg_idx_i]  <= cfg_addr_i;
      w_value_q[cfg_idx_i] <= cfg_value_i;
      w_mask_q[cfg_idx_i]  <= cfg_mask_i;
    end
  end

  // Sequencer FSM with window counter, hit pulse and sticky flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      stage_q    <= '0;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      sticky_q   <= 1'b0;
      // Treat arm as already high so a level held across reset cannot arm
      // the sequencer; a fresh low-to-high transition is required.
      arm_prev_q <= 1'b1;
    end else begin
      arm_prev_q <= arm_i;
      hit_q      <= 1'b0;

      // Setting (hit edge or hit cycle) takes priority over clear.
      if (final_match || hit_q) begin
        sticky_q <= 1'b1;
      end else if (clear_i) begin
        sticky_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          stage_q <= '0;
          cnt_q   <= '0;
          if (arm_rise) begin
            state_q <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (!arm_i) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            cnt_q   <= '0;
          end else if (cur_match) begin
            stage_q <= stage_q + STAGE_W'(1);
            cnt_q   <= '0;
            if (last_stage) begin
              state_q <= S_HIT;
              hit_q   <= 1'b1;
            end
          end else if (stage_q != '0) begin
            if (window_expire) begin
              stage_q <= '0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        S_HIT: begin
          state_q <= S_IDLE;
          stage_q <= '0;
          cnt_q   <= '0;
        end

        default: begin
          state_q <= S_IDLE;
          stage_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign cfg_ready_o  = (state_q == S_IDLE);
  assign stage_o      = stage_q;
  assign hit_o        = hit_q;
  assign hit_sticky_o = sticky_q;

`else
  // Watch logic absent: status tied off, configuration always accepted.
  logic unused_watch_inputs;
  assign unused_watch_inputs = ^{cfg_valid_i, cfg_idx_i, cfg_addr_i,
                                 cfg_value_i, cfg_mask_i, arm_i, clear_i};

  assign cfg_ready_o  = 1'b1;
  assign stage_o      = '0;
  assign hit_o        = 1'b0;
  assign hit_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_ariane_regfile_watch.sv
// Testbench for ariane_regfile_watch: table-driven register-file vectors plus
// hand-written sequences for the watch sequencer (when REGFILE_WATCH_EN is
// defined) or its tied-off outputs (when it is not).
module tb_ariane_regfile_watch;

  localparam int unsigned DW = 64;

  logic         clk;
  logic         rst_n;
  logic [9:0]   raddr;
  logic [127:0] rdata;
  logic [9:0]   waddr;
  logic [127:0] wdata;
  logic [1:0]   we;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_idx;
  logic [4:0]   cfg_addr;
  logic [63:0]  cfg_value;
  logic [63:0]  cfg_mask;
  logic         arm;
  logic         clear;
  logic [1:0]   stage;
  logic         hit;
  logic         hit_sticky;

  int checks   = 0;
  int failures = 0;

  ariane_regfile_watch #(
    .DATA_WIDTH    (DW),
    .NR_READ_PORTS (2),
    .NR_WRITE_PORTS(2),
    .ZERO_REG_ZERO (1'b1),
    .NR_WATCH      (2),
    .WINDOW        (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .raddr_i      (raddr),
    .rdata_o      (rdata),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .we_i         (we),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_idx_i    (cfg_idx),
    .cfg_addr_i   (cfg_addr),
    .cfg_value_i  (cfg_value),
    .cfg_mask_i   (cfg_mask),
    .arm_i        (arm),
    .clear_i      (clear),
    .stage_o      (stage),
    .hit_o        (hit),
    .hit_sticky_o (hit_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } rf_vec_t;

  rf_vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    waddr[4:0]  = a;
    wdata[63:0] = d;
    we          = 2'b01;
    tick();
    we          = 2'b00;
  endtask

  task automatic rd_check(input string name, input logic [4:0] a, input logic [63:0] exp);
    raddr[4:0] = a;
    #1;
    check(name, rdata[63:0], exp);
  endtask

  task automatic cfg(input logic idx, input logic [4:0] a, input logic [63:0] v,
                     input logic [63:0] m);
    cfg_valid = 1'b1;
    cfg_idx   = idx;
    cfg_addr  = a;
    cfg_value = v;
    cfg_mask  = m;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    // Register-file vectors: write both ports, then read back next cycle.
    vecs[0] = '{1'b1, 5'd5,  64'h11,                 1'b1, 5'd5,  64'h22,
                5'd5,  5'd5,  64'h22, 64'h22};
    vecs[1] = '{1'b1, 5'd0,  64'hdead,               1'b0, 5'd0,  64'h0,
                5'd0,  5'd5,  64'h0,  64'h22};
    vecs[2] = '{1'b1, 5'd1,  64'h0123456789abcdef,   1'b1, 5'd2,  64'hffffffffffffffff,
                5'd1,  5'd2,  64'h0123456789abcdef, 64'hffffffffffffffff};
    vecs[3] = '{1'b1, 5'd31, 64'ha5a5a5a5a5a5a5a5,   1'b1, 5'd30, 64'h5a5a5a5a5a5a5a5a,
                5'd31, 5'd30, 64'ha5a5a5a5a5a5a5a5, 64'h5a5a5a5a5a5a5a5a};
    vecs[4] = '{1'b1, 5'd7,  64'h77,                 1'b0, 5'd7,  64'h99,
                5'd7,  5'd1,  64'h77, 64'h0123456789abcdef};
    vecs[5] = '{1'b1, 5'd3,  64'haaaa,               1'b1, 5'd0,  64'hbbbb,
                5'd0,  5'd3,  64'h0,  64'haaaa};
    vecs[6] = '{1'b0, 5'd0,  64'h0,                  1'b0, 5'd0,  64'h0,
                5'd2,  5'd31, 64'hffffffffffffffff, 64'ha5a5a5a5a5a5a5a5};

    rst_n     = 1'b0;
    raddr     = '0;
    waddr     = '0;
    wdata     = '0;
    we        = '0;
    cfg_valid = 1'b0;
    cfg_idx   = 1'b0;
    cfg_addr  = '0;
    cfg_value = '0;
    cfg_mask  = '0;
    arm       = 1'b0;
    clear     = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state visible while reset is still asserted.
    check("reset_stage",  64'(stage),      64'd0);
    check("reset_hit",    64'(hit),        64'd0);
    check("reset_sticky", 64'(hit_sticky), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reset_ready", 64'(cfg_ready), 64'd1);
    rd_check("reset_mem_x5",  5'd5,  64'd0);
    rd_check("reset_mem_x16", 5'd16, 64'd0);

    for (int i = 0; i < 7; i++) begin
      waddr = {vecs[i].wa1, vecs[i].wa0};
      wdata = {vecs[i].wd1, vecs[i].wd0};
      we    = {vecs[i].we1, vecs[i].we0};
      tick();
      we    = 2'b00;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("rf_vec%0d_port0", i), rdata[63:0],   vecs[i].exp0);
      check($sformatf("rf_vec%0d_port1", i), rdata[127:64], vecs[i].exp1);
    end

`ifdef REGFILE_WATCH_EN
    // Program the two stages and run a full hit sequence.
    cfg(1'b0, 5'd16, 64'hFFFFFFFE00000000, 64'hFFFFFFFFFFFFFFFF);
    cfg(1'b1, 5'd17, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF);
    arm = 1'b1;
    tick();
    check("armed_ready", 64'(cfg_ready), 64'd0);
    check("armed_stage", 64'(stage),     64'd0);
    wr(5'd16, 64'hFFFFFFFE00000000);
    check("seq_write_edge_stage", 64'(stage), 64'd0);
    tick();
    check("seq_stage1", 64'(stage), 64'd1);
    wr(5'd17, 64'hFFFFFFFF80000000);
    check("seq_stage1_hold", 64'(stage), 64'd1);
    check("seq_no_hit_yet",  64'(hit),   64'd0);
    tick();
    check("seq_stage2", 64'(stage),      64'd2);
    check("seq_hit",    64'(hit),        64'd1);
    check("seq_sticky", 64'(hit_sticky), 64'd1);
    tick();
    check("seq_hit_pulse_end", 64'(hit),        64'd0);
    check("seq_idle_stage",    64'(stage),      64'd0);
    check("seq_sticky_hold",   64'(hit_sticky), 64'd1);
    check("seq_idle_ready",    64'(cfg_ready),  64'd1);

    // arm held high: no re-arm without a fresh rising edge.
    repeat (3) tick();
    check("no_rearm_ready", 64'(cfg_ready), 64'd1);
    check("no_rearm_hit",   64'(hit_sticky), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_sticky", 64'(hit_sticky), 64'd0);

    // Hit with clear_i asserted across the set edge and the hit cycle.
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    check("rearm_ready", 64'(cfg_ready), 64'd0);
    tick();
    check("rearm_stage1", 64'(stage), 64'd1);
    clear = 1'b1;
    tick();
    check("clr_set_hit",    64'(hit),        64'd1);
    check("clr_set_sticky", 64'(hit_sticky), 64'd1);
    tick();
    check("clr_set_sticky_after", 64'(hit_sticky), 64'd1);
    clear = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_sticky2", 64'(hit_sticky), 64'd0);

    // Window expiry: stage 1 reached, stage 1 never matches for 7 cycles.
    wr(5'd17, 64'h0);
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    tick();
    check("win_stage1", 64'(stage), 64'd1);
    wr(5'd16, 64'h0);
    repeat (5) tick();
    check("win_stage1_last", 64'(stage), 64'd1);
    tick();
    check("win_expired", 64'(stage), 64'd0);
    wr(5'd17, 64'hFFFFFFFF80000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("win_lone_x17_hit%0d", i), 64'(hit), 64'd0);
    end
    check("win_lone_x17_stage",  64'(stage),      64'd0);
    check("win_lone_x17_sticky", 64'(hit_sticky), 64'd0);

    // Config attempt while armed is refused; original config still hits.
    cfg_valid = 1'b1;
    cfg_idx   = 1'b1;
    cfg_addr  = 5'd20;
    cfg_value = 64'h1234;
    cfg_mask  = 64'hFFFFFFFFFFFFFFFF;
    #1;
    check("cfg_armed_ready", 64'(cfg_ready), 64'd0);
    wr(5'd16, 64'hFFFFFFFE00000000);
    tick();
    check("cfg_armed_stage1", 64'(stage), 64'd1);
    tick();
    check("cfg_unchanged_hit", 64'(hit), 64'd1);
    cfg_valid = 1'b0;
    tick();
    check("cfg_unchanged_idle", 64'(hit), 64'd0);

    // Disarm while in stage 1: back to IDLE, sticky untouched.
    wr(5'd17, 64'h0);
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    tick();
    check("disarm_pre_stage", 64'(stage), 64'd1);
    arm = 1'b0;
    tick();
    check("disarm_stage",  64'(stage),      64'd0);
    check("disarm_ready",  64'(cfg_ready),  64'd1);
    check("disarm_sticky", 64'(hit_sticky), 64'd1);

    // Reset mid-sequence, one edge before the hit would fire.
    wr(5'd17, 64'hFFFFFFFF80000000);
    arm = 1'b1;
    tick();
    tick();
    check("rst_pre_stage", 64'(stage), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_stage",  64'(stage),      64'd0);
    check("rst_async_hit",    64'(hit),        64'd0);
    check("rst_async_sticky", 64'(hit_sticky), 64'd0);
    check("rst_async_ready",  64'(cfg_ready),  64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_release_hit%0d", i),   64'(hit),   64'd0);
      check($sformatf("rst_release_stage%0d", i), 64'(stage), 64'd0);
    end
    rd_check("rst_mem_x16", 5'd16, 64'd0);

    // Cleared config has all-zero masks: stages advance every cycle.
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    check("mask0_armed_stage", 64'(stage), 64'd0);
    tick();
    check("mask0_stage1", 64'(stage), 64'd1);
    tick();
    check("mask0_stage2", 64'(stage),      64'd2);
    check("mask0_hit",    64'(hit),        64'd1);
    check("mask0_sticky", 64'(hit_sticky), 64'd1);
    tick();
    check("mask0_done", 64'(hit), 64'd0);
`else
    // Watch logic absent: status stays tied off whatever the controls do.
    cfg_valid = 1'b1;
    #1;
    check("nowatch_ready", 64'(cfg_ready), 64'd1);
    cfg(1'b0, 5'd16, 64'h0, 64'h0);
    cfg(1'b1, 5'd17, 64'h0, 64'h0);
    arm = 1'b1;
    wr(5'd16, 64'hFFFFFFFE00000000);
    wr(5'd17, 64'hFFFFFFFF80000000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("nowatch_stage%0d", i), 64'(stage),      64'd0);
      check($sformatf("nowatch_hit%0d", i),   64'(hit),        64'd0);
      check($sformatf("nowatch_sticky%0d", i), 64'(hit_sticky), 64'd0);
    end
    check("nowatch_ready_armed", 64'(cfg_ready), 64'd1);
    rd_check("nowatch_mem_x17", 5'd17, 64'hFFFFFFFF80000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
